sc_comp: RTL and testbench



---
 rtl/sc_comp.sv | 347 ++++++++++++++++++++++++++++++++++
 tb/tb_sc_comp.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sc_comp.sv
// Single-cycle RV32I-subset computer: CPU core, 128-word instruction ROM, 128-word data RAM.
// Latency: one instruction retires per core clock. Backpressure: none, the core never stalls.

// Register file: x1..x31 with async clear, two operand read ports plus a debug read port.
module sc_rf (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   input  logic [4:0]  ra1,
   output logic [31:0] rd1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd2,
   input  logic [4:0]  ra3,
   output logic [31:0] rd3
);
   logic [31:0] rf [1:31];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < 32; i++) rf[i] <= '0;
      end else if (we && (wa != 5'd0)) begin
         rf[wa] <= wd;
      end
   end

   // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
   assign rd1 = (ra1 == 5'd0) ? '0 : rf[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : rf[ra2];
   assign rd3 = (ra3 == 5'd0) ? '0 : rf[ra3];
endmodule

// Instruction ROM: combinational word read, optional programming port for board loaders.
module sc_im (
   input  logic        clk,
   input  logic        load_en,
   input  logic [6:0]  load_addr,
   input  logic [31:0] load_data,
   input  logic [6:0]  addr,
   output logic [31:0] dout
);
   logic [31:0] ROM [0:127];

   always_ff @(posedge clk) begin
      if (load_en) ROM[load_addr] <= load_data;
   end

   assign dout = ROM[addr];
endmodule

// Data RAM: combinational word read, write on rising edge; contents survive reset.
module sc_dm (
   input  logic        clk,
   input  logic        we,
   input  logic [6:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);
   logic [31:0] RAM [0:127];

   always_ff @(posedge clk) begin
      if (we) RAM[addr] <= wdata;
   end

   assign rdata = RAM[addr];
endmodule

// CPU core: decode, ALU, branch unit and PC; commits PC, one RF write and one store per edge.
module sc_cpu (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   output logic [31:0] PC_out,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   input  logic [4:0]  reg_sel,
   output logic [31:0] reg_data
);
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } alu_op_t;
   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;
   typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] pc, pc_next, pc_plus4, pc_target;
   logic [31:0] rs1_val, rs2_val, imm, alu_a, alu_b, alu_res, wb_data;
   logic [4:0]  shamt;
   logic        rf_we, b_imm, is_branch, is_jal, is_jalr, is_store, br_taken;
   alu_op_t     alu_op;
   wb_sel_t     wb_sel;
   a_sel_t      a_sel;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // Anything not recognised leaves all enables low, which makes it a NOP.
   always_comb begin
      rf_we     = 1'b0;
      wb_sel    = WB_ALU;
      alu_op    = ALU_ADD;
      a_sel     = A_RS1;
      b_imm     = 1'b0;
      imm       = imm_i;
      is_branch = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      is_store  = 1'b0;
      case (opcode)
         OP_R: begin
            rf_we = 1'b1;
            case ({funct7, funct3})
               10'b0000000_000: alu_op = ALU_ADD;
               10'b0100000_000: alu_op = ALU_SUB;
               10'b0000000_111: alu_op = ALU_AND;
               10'b0000000_110: alu_op = ALU_OR;
               10'b0000000_100: alu_op = ALU_XOR;
               10'b0000000_001: alu_op = ALU_SLL;
               10'b0000000_101: alu_op = ALU_SRL;
               10'b0100000_101: alu_op = ALU_SRA;
               10'b0000000_010: alu_op = ALU_SLT;
               10'b0000000_011: alu_op = ALU_SLTU;
               default:         rf_we  = 1'b0;
            endcase
         end
         OP_I: begin
            rf_we = 1'b1;
            b_imm = 1'b1;
            case (funct3)
               3'b000: alu_op = ALU_ADD;
               3'b010: alu_op = ALU_SLT;
               3'b011: alu_op = ALU_SLTU;
               3'b100: alu_op = ALU_XOR;
               3'b110: alu_op = ALU_OR;
               3'b111: alu_op = ALU_AND;
               3'b001: begin
                  if (funct7 == 7'b0000000) alu_op = ALU_SLL;
                  else rf_we = 1'b0;
               end
               default: begin
                  if (funct7 == 7'b0000000)      alu_op = ALU_SRL;
                  else if (funct7 == 7'b0100000) alu_op = ALU_SRA;
                  else rf_we = 1'b0;
               end
            endcase
         end
         OP_LUI: begin
            rf_we = 1'b1;
            a_sel = A_ZERO;
            b_imm = 1'b1;
            imm   = imm_u;
         end
         OP_AUIPC: begin
            rf_we = 1'b1;
            a_sel = A_PC;
            b_imm = 1'b1;
            imm   = imm_u;
         end
         OP_LOAD: begin
            if (funct3 == 3'b010) begin
               rf_we  = 1'b1;
               b_imm  = 1'b1;
               wb_sel = WB_MEM;
            end
         end
         OP_STORE: begin
            b_imm = 1'b1;
            imm   = imm_s;
            if (funct3 == 3'b010) is_store = 1'b1;
         end
         OP_BRANCH: begin
            imm       = imm_b;
            is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
         end
         OP_JAL: begin
            rf_we  = 1'b1;
            wb_sel = WB_PC4;
            imm    = imm_j;
            is_jal = 1'b1;
         end
         OP_JALR: begin
            b_imm = 1'b1;
            if (funct3 == 3'b000) begin
               rf_we   = 1'b1;
               wb_sel  = WB_PC4;
               is_jalr = 1'b1;
            end
         end
         default: ;
      endcase
   end

   sc_rf U_RF (
      .clk (clk),
      .rst (rst),
      .we  (rf_we),
      .wa  (rd),
      .wd  (wb_data),
      .ra1 (rs1),
      .rd1 (rs1_val),
      .ra2 (rs2),
      .rd2 (rs2_val),
      .ra3 (reg_sel),
      .rd3 (reg_data)
   );

   always_comb begin
      case (a_sel)
         A_PC:    alu_a = pc;
         A_ZERO:  alu_a = '0;
         default: alu_a = rs1_val;
      endcase
   end

   assign alu_b = b_imm ? imm : rs2_val;
   assign shamt = alu_b[4:0];

   always_comb begin
      case (alu_op)
         ALU_ADD:  alu_res = alu_a + alu_b;
         ALU_SUB:  alu_res = alu_a - alu_b;
         ALU_AND:  alu_res = alu_a & alu_b;
         ALU_OR:   alu_res = alu_a | alu_b;
         ALU_XOR:  alu_res = alu_a ^ alu_b;
         ALU_SLL:  alu_res = alu_a << shamt;
         ALU_SRL:  alu_res = alu_a >> shamt;
         ALU_SRA:  alu_res = $unsigned($signed(alu_a) >>> shamt);
         ALU_SLT:  alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLTU: alu_res = {31'b0, alu_a < alu_b};
         default:  alu_res = '0;
      endcase
   end

   // Branch compare is independent of the ALU, which is busy with nothing else here anyway.
   always_comb begin
      case (funct3)
         3'b000:  br_taken = (rs1_val == rs2_val);
         3'b001:  br_taken = (rs1_val != rs2_val);
         3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
         3'b101:  br_taken = !($signed(rs1_val) < $signed(rs2_val));
         3'b110:  br_taken = (rs1_val < rs2_val);
         3'b111:  br_taken = !(rs1_val < rs2_val);
         default: br_taken = 1'b0;
      endcase
   end

   assign pc_plus4  = pc + 32'd4;
   assign pc_target = pc + imm;

   always_comb begin
      if (is_jalr)                          pc_next = alu_res & ~32'd1;
      else if (is_jal || (is_branch && br_taken)) pc_next = pc_target;
      else                                  pc_next = pc_plus4;
   end

   always_comb begin
      case (wb_sel)
         WB_MEM:  wb_data = mem_rdata;
         WB_PC4:  wb_data = pc_plus4;
         default: wb_data = alu_res;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pc <= '0;
      else     pc <= pc_next;
   end

   assign PC_out    = pc;
   assign mem_addr  = alu_res;
   assign mem_wdata = rs2_val;
   // A store caught by reset must not land in memory, which reset does not clear.
   assign mem_we    = is_store & ~rst;
endmodule

// Top level: wires the core to ROM and RAM and exposes the debug register read.
module sc_comp (
   input  logic        clk,
   input  logic        rstn,
   input  logic [4:0]  reg_sel,
   output logic [31:0] reg_data
);
   logic [31:0] PC, instr;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        dm_we;
   logic        unused_addr_bits;

   sc_cpu U_SCPU (
      .clk       (clk),
      .rst       (rstn),
      .instr     (instr),
      .PC_out    (PC),
      .mem_addr  (dm_addr),
      .mem_wdata (dm_wdata),
      .mem_we    (dm_we),
      .mem_rdata (dm_rdata),
      .reg_sel   (reg_sel),
      .reg_data  (reg_data)
   );

   sc_im U_IM (
      .clk       (clk),
      .load_en   (1'b0),
      .load_addr (7'd0),
      .load_data (32'd0),
      .addr      (PC[8:2]),
      .dout      (instr)
   );

   sc_dm U_DM (
      .clk   (clk),
      .we    (dm_we),
      .addr  (dm_addr[8:2]),
      .wdata (dm_wdata),
      .rdata (dm_rdata)
   );

   // Both memories decode only bits 8:2; the rest of each address wraps.
   assign unused_addr_bits = ^{PC[31:9], PC[1:0], dm_addr[31:9], dm_addr[1:0]};
endmodule

// File: tb/tb_sc_comp.sv
// Directed bench for sc_comp: one program covering ALU, memory, branches, jumps, x0, NOP and reset.
module tb_sc_comp;
   logic        clk = 1'b0;
   logic        rstn;
   logic [4:0]  reg_sel;
   logic [31:0] reg_data;
   int          checks = 0;
   int          failures = 0;

   logic [31:0] prog [0:23] = '{
      32'h00500093, 32'h00300113, 32'h002081B3, 32'h40208233,
      32'h00108463, 32'h00000000, 32'h123452B7, 32'h00302023,
      32'h008000EF, 32'h00C08093, 32'h00008067, 32'h00000000,
      32'h00002303, 32'h00211463, 32'h00209463, 32'h00000000,
      32'h00700013, 32'h00000000, 32'hFFF00393, 32'h0013A433,
      32'h0013B4B3, 32'h01C3D593, 32'h4043D513, 32'h00209633
   };

   sc_comp dut (
      .clk      (clk),
      .rstn     (rstn),
      .reg_sel  (reg_sel),
      .reg_data (reg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      rstn    = 1'b1;
      reg_sel = 5'd0;
      for (int i = 0; i < 128; i++) dut.U_IM.ROM[i] <= (i < 24) ? prog[i] : 32'h0;
      repeat (2) @(posedge clk);
      #2;

      // Reset state
      chk("reset_pc", dut.PC, 32'h0);
      for (int i = 1; i < 32; i++) chk($sformatf("reset_rf%0d", i), dut.U_SCPU.U_RF.rf[i], 32'h0);
      for (int s = 0; s < 32; s++) begin
         reg_sel = 5'(s);
         #1;
         chk($sformatf("reset_dbg%0d", s), reg_data, 32'h0);
      end
      chk("reset_pc_out", dut.U_SCPU.PC_out, 32'h0);

      // ALU program
      rstn = 1'b0;
      repeat (4) tick();
      chk("alu_x1", dut.U_SCPU.U_RF.rf[1], 32'd5);
      chk("alu_x2", dut.U_SCPU.U_RF.rf[2], 32'd3);
      chk("alu_x3", dut.U_SCPU.U_RF.rf[3], 32'd8);
      chk("alu_x4", dut.U_SCPU.U_RF.rf[4], 32'd2);
      chk("alu_pc", dut.PC, 32'h10);

      // beq taken
      tick();
      chk("beq_pc", dut.PC, 32'h18);

      // lui, sw
      tick();
      chk("lui_x5", dut.U_SCPU.U_RF.rf[5], 32'h12345000);
      tick();
      chk("sw_dm0", dut.U_DM.RAM[0], 32'd8);
      chk("sw_pc", dut.PC, 32'h20);

      // jal, jalr back, addi, jalr forward
      tick();
      chk("jal_x1", dut.U_SCPU.U_RF.rf[1], 32'h24);
      chk("jal_pc", dut.PC, 32'h28);
      tick();
      chk("jalr_pc", dut.PC, 32'h24);
      tick();
      chk("addi_x1", dut.U_SCPU.U_RF.rf[1], 32'h30);
      tick();
      chk("jalr2_pc", dut.PC, 32'h30);

      // lw
      tick();
      chk("lw_x6", dut.U_SCPU.U_RF.rf[6], 32'd8);
      chk("lw_pc", dut.PC, 32'h34);

      // bne not taken (equal), then taken (x1 != x2)
      tick();
      chk("bne_eq_pc", dut.PC, 32'h38);
      tick();
      chk("bne_ne_pc", dut.PC, 32'h40);

      // addi x0 is dropped
      tick();
      reg_sel = 5'd0;
      #1;
      chk("x0_dbg", reg_data, 32'h0);
      chk("x0_pc", dut.PC, 32'h44);

      // undefined opcode 0 behaves as NOP
      tick();
      chk("nop_pc", dut.PC, 32'h48);
      chk("nop_x1", dut.U_SCPU.U_RF.rf[1], 32'h30);
      chk("nop_x2", dut.U_SCPU.U_RF.rf[2], 32'd3);
      chk("nop_x3", dut.U_SCPU.U_RF.rf[3], 32'd8);
      chk("nop_x4", dut.U_SCPU.U_RF.rf[4], 32'd2);
      chk("nop_x5", dut.U_SCPU.U_RF.rf[5], 32'h12345000);
      chk("nop_x6", dut.U_SCPU.U_RF.rf[6], 32'd8);
      chk("nop_x7", dut.U_SCPU.U_RF.rf[7], 32'h0);

      // addi x7,-1 and debug port reads
      tick();
      reg_sel = 5'd7;
      #1;
      chk("dbg_x7", reg_data, 32'hFFFFFFFF);
      reg_sel = 5'd3;
      #1;
      chk("dbg_x3", reg_data, 32'd8);

      // slt, sltu, srli, srai, sll
      tick();
      chk("slt_x8", dut.U_SCPU.U_RF.rf[8], 32'd1);
      tick();
      chk("sltu_x9", dut.U_SCPU.U_RF.rf[9], 32'd0);
      tick();
      chk("srli_x11", dut.U_SCPU.U_RF.rf[11], 32'h0000000F);
      tick();
      chk("srai_x10", dut.U_SCPU.U_RF.rf[10], 32'hFFFFFFFF);
      tick();
      chk("sll_x12", dut.U_SCPU.U_RF.rf[12], 32'h180);
      chk("sll_pc", dut.PC, 32'h60);

      // Asynchronous reset mid-program
      rstn = 1'b1;
      #1;
      chk("midrst_pc", dut.PC, 32'h0);
      chk("midrst_x12", dut.U_SCPU.U_RF.rf[12], 32'h0);
      reg_sel = 5'd1;
      #1;
      chk("midrst_dbg1", reg_data, 32'h0);
      tick();
      chk("midrst_hold_pc", dut.PC, 32'h0);
      rstn = 1'b0;
      tick();
      chk("restart_pc", dut.PC, 32'h4);
      chk("restart_x1", dut.U_SCPU.U_RF.rf[1], 32'd5);
      chk("restart_x2", dut.U_SCPU.U_RF.rf[2], 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
